// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StRespond
  } state_e;

  // Byte offset width within a line: 2 bits of byte select plus the word select.
  function automatic int unsigned offset_bit(input int unsigned line_word_bit);
    return 2 + line_word_bit;
  endfunction

  // Tag width: everything above the offset and set index in a 32-bit address.
  function automatic int unsigned tag_bit(input int unsigned index_bit,
                                          input int unsigned line_word_bit);
    return 32 - offset_bit(line_word_bit) - index_bit;
  endfunction

  // Way select width; a direct-mapped cache still carries a 1-bit way field.
  function automatic int unsigned way_bit(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_tag_store.sv
// Valid/tag arrays and per-set FIFO victim pointers with a combinational lookup.
module icache_tag_store
  import icache_pkg::*;
#(
  parameter int unsigned WAYS      = 2,
  parameter int unsigned INDEX_BIT = 2,
  parameter int unsigned TAG_BIT   = 26,
  parameter int unsigned WAY_BIT   = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [INDEX_BIT-1:0] lookup_index,
  input  logic [TAG_BIT-1:0]   lookup_tag,
  output logic                 hit,
  output logic [WAY_BIT-1:0]   hit_way,
  output logic [WAY_BIT-1:0]   victim_way,
  input  logic                 install,
  input  logic [INDEX_BIT-1:0] install_index,
  input  logic [WAY_BIT-1:0]   install_way,
  input  logic [TAG_BIT-1:0]   install_tag,
  input  logic                 flush_all
);

  localparam int unsigned SETS = 1 << INDEX_BIT;

  logic [WAYS-1:0]    valid_q [SETS];
  logic [TAG_BIT-1:0] tag_q   [SETS][WAYS];
  logic [WAY_BIT-1:0] ptr_q   [SETS];

  // Tag compare across the set, and victim choice: lowest invalid way, else FIFO pointer.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = ptr_q[lookup_index];
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[lookup_index][w]) begin
        victim_way = WAY_BIT'(w);
      end
    end
    for (int w = 0; w < int'(WAYS); w++) begin
      if (valid_q[lookup_index][w] && (tag_q[lookup_index][w] == lookup_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BIT'(w);
      end
    end
  end

  // Array state: flush clears every valid bit, install writes one way and advances FIFO.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          tag_q[s][w] <= '0;
        end
      end
    end else if (flush_all) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
      end
    end else if (install) begin
      valid_q[install_index][install_way] <= 1'b1;
      tag_q[install_index][install_way]   <= install_tag;
      // Only replacing a live line moves the pointer; filling a hole leaves it alone.
      if (valid_q[install_index][install_way]) begin
        if (ptr_q[install_index] == WAY_BIT'(WAYS - 1)) begin
          ptr_q[install_index] <= '0;
        end else begin
          ptr_q[install_index] <= ptr_q[install_index] + WAY_BIT'(1);
        end
      end
    end
  end

endmodule

// File: rtl/icache_set_assoc.sv
// N-way set-associative instruction cache: 1-cycle hits, word-by-word line refill on miss.
module icache_set_assoc
  import icache_pkg::*;
#(
  parameter int unsigned WAYS          = 2,
  parameter int unsigned INDEX_BIT     = 2,
  parameter int unsigned LINE_WORD_BIT = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
);

  localparam int unsigned SETS       = 1 << INDEX_BIT;
  localparam int unsigned WORDS      = 1 << LINE_WORD_BIT;
  localparam int unsigned OFFSET_BIT = offset_bit(LINE_WORD_BIT);
  localparam int unsigned TAG_BIT    = tag_bit(INDEX_BIT, LINE_WORD_BIT);
  localparam int unsigned WAY_BIT    = way_bit(WAYS);

  logic [LINE_WORD_BIT-1:0] req_word;
  logic [INDEX_BIT-1:0]     req_index;
  logic [TAG_BIT-1:0]       req_tag;
  logic                     unused_addr_bits;

  assign req_word         = req_addr[OFFSET_BIT-1:2];
  assign req_index        = req_addr[OFFSET_BIT+INDEX_BIT-1:OFFSET_BIT];
  assign req_tag          = req_addr[31:OFFSET_BIT+INDEX_BIT];
  assign unused_addr_bits = ^req_addr[1:0];

  state_e                   state_q, state_d;
  logic [LINE_WORD_BIT-1:0] cnt_q, cnt_d;
  logic [LINE_WORD_BIT-1:0] word_q, word_d;
  logic [INDEX_BIT-1:0]     index_q, index_d;
  logic [TAG_BIT-1:0]       tag_q, tag_d;
  logic [WAY_BIT-1:0]       victim_q, victim_d;
  logic                     flush_pending_q, flush_pending_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [31:0]              resp_data_q, resp_data_d;
  logic                     mem_req_q, mem_req_d;
  logic [31:0]              mem_addr_q, mem_addr_d;

  logic                     ready_c;
  logic                     install_c;
  logic                     flush_all_c;
  logic                     data_we_c;

  logic                     hit;
  logic [WAY_BIT-1:0]       hit_way;
  logic [WAY_BIT-1:0]       victim_way;
  logic [INDEX_BIT-1:0]     lookup_index;

  logic [31:0]              data_q [WAYS][SETS][WORDS];

  // Outside IDLE the tag store is pointed at the set being refilled.
  assign lookup_index = (state_q == StIdle) ? req_index : index_q;

  icache_tag_store #(
    .WAYS      (WAYS),
    .INDEX_BIT (INDEX_BIT),
    .TAG_BIT   (TAG_BIT),
    .WAY_BIT   (WAY_BIT)
  ) u_tag_store (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .lookup_index  (lookup_index),
    .lookup_tag    (req_tag),
    .hit           (hit),
    .hit_way       (hit_way),
    .victim_way    (victim_way),
    .install       (install_c & rdy_in),
    .install_index (index_q),
    .install_way   (victim_q),
    .install_tag   (tag_q),
    .flush_all     (flush_all_c & rdy_in)
  );

  // FSM next state, refill sequencing and response generation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    word_d          = word_q;
    index_d         = index_q;
    tag_d           = tag_q;
    victim_d        = victim_q;
    flush_pending_d = flush_pending_q;
    resp_valid_d    = 1'b0;
    resp_data_d     = resp_data_q;
    mem_req_d       = mem_req_q;
    mem_addr_d      = mem_addr_q;
    ready_c         = 1'b0;
    install_c       = 1'b0;
    flush_all_c     = 1'b0;
    data_we_c       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush || flush_pending_q) begin
          flush_all_c     = 1'b1;
          flush_pending_d = 1'b0;
        end else begin
          ready_c = 1'b1;
          if (req_valid) begin
            if (hit) begin
              resp_valid_d = 1'b1;
              resp_data_d  = data_q[hit_way][req_index][req_word];
            end else begin
              word_d     = req_word;
              index_d    = req_index;
              tag_d      = req_tag;
              victim_d   = victim_way;
              cnt_d      = '0;
              mem_req_d  = 1'b1;
              mem_addr_d = {req_tag, req_index, {LINE_WORD_BIT{1'b0}}, 2'b00};
              state_d    = StRefill;
            end
          end
        end
      end
      StRefill: begin
        if (flush) begin
          flush_pending_d = 1'b1;
        end
        if (mem_req_q) begin
          if (mem_ack) begin
            data_we_c = 1'b1;
            mem_req_d = 1'b0;
            cnt_d     = cnt_q + LINE_WORD_BIT'(1);
            if (cnt_q == '1) begin
              install_c = 1'b1;
              state_d   = StRespond;
            end
          end
        end else begin
          // Re-issue one cycle after each ack for the next word of the line.
          mem_req_d  = 1'b1;
          mem_addr_d = {tag_q, index_q, cnt_q, 2'b00};
        end
      end
      StRespond: begin
        if (flush) begin
          flush_pending_d = 1'b1;
        end
        resp_valid_d = 1'b1;
        resp_data_d  = data_q[victim_q][index_q][word_q];
        state_d      = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      word_q          <= '0;
      index_q         <= '0;
      tag_q           <= '0;
      victim_q        <= '0;
      flush_pending_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
    end else if (rdy_in) begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      word_q          <= word_d;
      index_q         <= index_d;
      tag_q           <= tag_d;
      victim_q        <= victim_d;
      flush_pending_q <= flush_pending_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      mem_req_q       <= mem_req_d;
      mem_addr_q      <= mem_addr_d;
    end
  end

  // Line data array; only written by refill acks, so it needs no reset.
  always_ff @(posedge clk_in) begin
    if (rdy_in && data_we_c) begin
      data_q[victim_q][index_q][cnt_q] <= mem_data;
    end
  end

  // A stalled cache must not advertise acceptance it cannot honour.
  assign req_ready  = ready_c & rdy_in;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache_set_assoc.sv
// Self-checking bench for icache_set_assoc against a line-level cache model.
module tb_icache_set_assoc;

  localparam int unsigned WAYS  = 2;
  localparam int unsigned SETS  = 4;
  localparam int unsigned WORDS = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush, req_valid, req_ready, resp_valid;
  logic [31:0] req_addr, resp_data, mem_addr, mem_data;
  logic        mem_req, mem_ack;

  icache_set_assoc #(
    .WAYS          (2),
    .INDEX_BIT     (2),
    .LINE_WORD_BIT (2)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] mem_log[$];
  int wait_cnt = 0;

  // Reference model: which line base address lives in each way of each set.
  bit          m_valid [SETS][WAYS];
  logic [31:0] m_line  [SETS][WAYS];
  int          m_ptr   [SETS];

  function automatic int m_set(input logic [31:0] a);
    return int'((a >> 4) & 32'(SETS - 1));
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s = m_set(a);
    for (int w = 0; w < int'(WAYS); w++)
      if (m_valid[s][w] && m_line[s][w] == (a & ~32'hF)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_fill(input logic [31:0] a);
    int s = m_set(a);
    int v = -1;
    for (int w = 0; w < int'(WAYS); w++)
      if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % int'(WAYS);
    end
    m_valid[s][v] = 1'b1;
    m_line[s][v]  = a & ~32'hF;
  endfunction

  function automatic void m_clear(input bit full);
    for (int s = 0; s < int'(SETS); s++) begin
      for (int w = 0; w < int'(WAYS); w++) m_valid[s][w] = 1'b0;
      if (full) m_ptr[s] = 0;
    end
  endfunction

  // Memory: data = addr ^ KEY after 1-3 cycles; acks only count when rdy_in is high.
  initial begin
    bit consumed;
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk_in);
      consumed = rst_in && rdy_in && mem_req && mem_ack;
      if (consumed) mem_log.push_back(mem_addr);
      #2;
      if (!rst_in) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (consumed) begin
        mem_ack = 1'b0;
      end else if (mem_req && !mem_ack) begin
        if (wait_cnt == 0) wait_cnt = $urandom_range(1, 3);
        wait_cnt--;
        if (wait_cnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = mem_addr ^ KEY;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic [31:0] a);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout: got %b want 1 for addr %h", req_ready, a);
    end
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clk_in);
    req_valid = 1'b0;
  endtask

  task automatic check_req(input logic [31:0] a, input int flush_at, input bit stall,
                           input string name);
    bit exp_hit, got_resp, ready_bad, stalled, seq_ok;
    logic [31:0] got_data, saved, want;
    int sz;
    exp_hit = m_hit(a);
    want    = {a[31:2], 2'b00} ^ KEY;
    mem_log.delete();
    do_req(a);
    n_cmp++;
    if (resp_valid !== exp_hit) begin
      n_bad++;
      $display("FAIL %s_hit addr %h: got resp_valid %b want %b", name, a, resp_valid, exp_hit);
    end
    if (exp_hit) begin
      n_cmp++;
      if (resp_data !== want) begin
        n_bad++;
        $display("FAIL %s_hit_data: got %h want %h", name, resp_data, want);
      end
    end else begin
      got_resp = 0; ready_bad = 0; stalled = 0; got_data = '0;
      for (int i = 0; i < 200; i++) begin
        if (resp_valid === 1'b1) begin
          got_resp = 1;
          got_data = resp_data;
          break;
        end
        if (req_ready !== 1'b0) ready_bad = 1;
        flush = (i == flush_at);
        if (stall && !stalled && mem_req && mem_ack) begin
          stalled = 1;
          saved   = mem_addr;
          sz      = mem_log.size();
          rdy_in  = 1'b0;
          repeat (3) @(negedge clk_in);
          n_cmp++;
          if (mem_addr !== saved || mem_req !== 1'b1 || mem_log.size() != sz) begin
            n_bad++;
            $display("FAIL %s_stall_freeze: got addr %h words %0d want addr %h words %0d",
                     name, mem_addr, mem_log.size(), saved, sz);
          end
          rdy_in = 1'b1;
        end
        @(negedge clk_in);
      end
      flush = 1'b0;
      n_cmp++;
      if (!got_resp || got_data !== want) begin
        n_bad++;
        $display("FAIL %s_miss_resp: got valid %b data %h want 1 %h", name, got_resp, got_data,
                 want);
      end
      seq_ok = (mem_log.size() == WORDS);
      if (seq_ok)
        for (int i = 0; i < int'(WORDS); i++)
          if (mem_log[i] !== (a & ~32'hF) + 32'(4 * i)) seq_ok = 0;
      n_cmp++;
      if (!seq_ok) begin
        n_bad++;
        $display("FAIL %s_mem_seq: got %0d words (first %h) want 4 from %h", name,
                 mem_log.size(), (mem_log.size() > 0) ? mem_log[0] : 32'h0, a & ~32'hF);
      end
      n_cmp++;
      if (ready_bad) begin
        n_bad++;
        $display("FAIL %s_ready_during_refill: got 1 want 0", name);
      end
      if (stall) begin
        n_cmp++;
        if (!stalled) begin
          n_bad++;
          $display("FAIL %s_stall_applied: got 0 want 1", name);
        end
      end
      @(negedge clk_in);
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_resp_pulse: got %b want 0", name, resp_valid);
      end
      m_fill(a);
      if (flush_at >= 0) m_clear(1'b0);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_cmp++;
    if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++;
    if (resp_data !== 32'h0) begin n_bad++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    n_cmp++;
    if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_cmp++;
    if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
  endtask

  task automatic test_back_to_back();
    int mreq = 0;
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin @(negedge clk_in); n++; end
    req_valid = 1'b1;
    req_addr  = 32'h0000_100C;
    @(negedge clk_in);
    mreq += int'(mem_req);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hA5A5_100C || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first: got v%b %h rdy%b want v1 a5a5100c rdy1", resp_valid, resp_data,
               req_ready);
    end
    req_addr = 32'h0000_1000;
    @(negedge clk_in);
    req_valid = 1'b0;
    mreq += int'(mem_req);
    n_cmp++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hA5A5_1000) begin
      n_bad++;
      $display("FAIL b2b_second: got v%b %h want v1 a5a51000", resp_valid, resp_data);
    end
    @(negedge clk_in);
    mreq += int'(mem_req);
    n_cmp++;
    if (resp_valid !== 1'b0 || mreq != 0) begin
      n_bad++;
      $display("FAIL b2b_quiet: got resp_valid %b mem_req cycles %0d want 0 0", resp_valid, mreq);
    end
  endtask

  task automatic test_fifo();
    check_req(32'h0000_2000, -1, 1'b0, "fifo_fill2");
    check_req(32'h0000_3000, -1, 1'b0, "fifo_evict0");
    check_req(32'h0000_2004, -1, 1'b0, "fifo_hit2");
    check_req(32'h0000_1000, -1, 1'b0, "fifo_evict1");
  endtask

  task automatic test_flush();
    flush = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    @(negedge clk_in);
    flush = 1'b0;
    m_clear(1'b0);
    check_req(32'h0000_1000, 2, 1'b0, "flush_in_refill");
    check_req(32'h0000_1000, -1, 1'b0, "flush_after");
  endtask

  task automatic test_stall();
    check_req(32'h0000_4010, -1, 1'b1, "stall");
    check_req(32'h0000_4018, -1, 1'b0, "stall_hit");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(1, 6)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      check_req(a, ($urandom_range(0, 7) == 0) ? 1 : -1, $urandom_range(0, 5) == 0, "rand");
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_req(32'h0000_7000);
    while (mem_req !== 1'b1 && n < 50) begin @(negedge clk_in); n++; end
    #2;
    rst_in = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || resp_valid !== 1'b0 || mem_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: got req %b valid %b addr %h want 0 0 0", mem_req, resp_valid,
               mem_addr);
    end
    @(negedge clk_in);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    @(negedge clk_in);
    m_clear(1'b1);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL async_release_ready: got %b want 1", req_ready); end
    check_req(32'h0000_1000, -1, 1'b0, "post_reset");
  endtask

  initial begin
    rst_in    = 1'b0;
    rdy_in    = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    m_clear(1'b1);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    test_reset();
    check_req(32'h0000_1008, -1, 1'b0, "cold_miss");
    test_back_to_back();
    test_fifo();
    test_flush();
    test_stall();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_set_assoc.md
Name: icache_set_assoc

Overview:
Parametrised N-way set-associative instruction cache with multi-word lines, sitting between instruction fetch and the memory controller.
- Fetch presents a word address; hits answer one cycle later.
- Misses run a refill FSM that reads the whole line word-by-word from memory, installs it with FIFO replacement, then answers.
- Adds a flush input that invalidates every line.

Parameters:
WAYS, 2, associativity; power of two, ≥1
INDEX_BIT, 2, log2(sets)
LINE_WORD_BIT, 2, log2(words per line); line = 4<<LINE_WORD_BIT bytes

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; when 0 every register holds and all inputs are ignored
flush  in  1  invalidate all lines
req_valid  in  1  fetch request
req_addr  in  32  fetch byte address; [1:0] ignored
req_ready  out  1  cache can accept a request this cycle
resp_valid  out  1  one-cycle pulse, resp_data valid
resp_data  out  32  instruction word
mem_req  out  1  word read request, held until acked
mem_addr  out  32  word address, [1:0]=0
mem_ack  in  1  mem_data valid, consumes the current mem_req
mem_data  in  32  read data

Behaviour:
- Address split: word = addr[2+LINE_WORD_BIT-1:2]; index = next INDEX_BIT bits; tag = addr[31:2+LINE_WORD_BIT+INDEX_BIT].
- Reset (rst_in=0, takes effect immediately):
  - All valid bits 0; all victim pointers 0; state IDLE; refill counter 0; flush_pending 0.
  - resp_valid=0, resp_data=0, mem_req=0, mem_addr=0, req_ready=1 once released.
  - Reset mid-refill abandons the refill; no line is installed.
- States: IDLE, REFILL, RESPOND.
- IDLE:
  - req_ready = !flush.
  - flush=1: clear all valid bits next edge; req_valid is ignored that cycle.
  - req_valid && req_ready: tag compare across all ways of the set, combinational on req_addr.
  - Hit (at most one way matches by construction): next cycle resp_valid=1 and resp_data=word; stay in IDLE.
  - Back-to-back hits sustain 1 request per cycle.
  - Miss: latch the address, choose the victim, go to REFILL with counter=0.
- Victim selection: lowest-index invalid way in the set; otherwise the set's victim pointer. The pointer increments mod WAYS only when a valid line in that set is replaced (FIFO). Hits do not touch it.
- REFILL:
  - req_ready=0.
  - mem_req=1 with mem_addr = line base + 4*counter.
  - Each mem_ack writes mem_data into victim word[counter] and increments counter.
  - The new mem_req appears the cycle after the ack, so mem_req is low for one cycle between words.
  - On the ack of the last word: set valid and tag for the victim, update the pointer, go to RESPOND.
  - No request is issued for a word beyond the line; words always fill from 0 to 2^LINE_WORD_BIT−1, with no critical-word-first.
- RESPOND: resp_valid=1 for one cycle with the requested word of the fresh line; go to IDLE.
- Flush asserted during REFILL/RESPOND: latched into flush_pending. The refill completes and its response is delivered, then all lines are invalidated on the IDLE entry cycle (req_ready=0 that cycle).
- resp_valid is 0 in every cycle not listed above. resp_data holds its last value.
- rdy_in=0: FSM, arrays, counters and outputs freeze; mem_ack and req_valid are ignored. mem_req stays as it was, and the memory side is expected to stall with it.
- A request arriving while req_ready=0 is not accepted; fetch must hold it.

Decomposition:
- Package icache_pkg: state enum (IDLE/REFILL/RESPOND), and functions/constants for TAG_BIT, OFFSET_BIT and WAY_BIT derived from the parameters.
- Sub-module icache_tag_store: owns the valid/tag arrays and per-set victim pointers, with a combinational hit/hit_way lookup, a victim output, install and flush-all ports.
- The data array and FSM live in the top.

Test Plan:
Defaults throughout. Memory model returns mem_data = mem_addr ^ 32'hA5A5_0000 with 1–3 cycle ack delay.
- Cold miss: after reset, req 0x0000_1008 → mem_addr sequence 0x1000, 0x1004, 0x1008, 0x100C; one resp_valid with resp_data 0xA5A5_1008 the cycle after RESPOND is entered; req_ready=0 throughout.
- Hit: then req 0x100C, 0x1000 back-to-back → resp_data 0xA5A5_100C, 0xA5A5_1000 on consecutive cycles; mem_req stays 0.
- FIFO replacement: fill 0x1000 and 0x2000 (both set 0), then 0x3000 → evicts way 0 (0x1000). Req 0x2004 hits; req 0x1000 misses, refills and evicts way 1 (0x2000).
- Flush: flush pulsed during the 0x1000 refill → response 0xA5A5_1000 still delivered; the following req 0x1000 misses.
- Stall: rdy_in=0 for 3 cycles during REFILL with mem_ack=1 → no counter advance and mem_addr unchanged; the address sequence and response are identical to an unstalled run.
- Async reset: rst_in low mid-REFILL, between clock edges → mem_req=0 and resp_valid=0 immediately. After release, req 0x1000 misses.
